// File: rtl/mario_jump_ctrl.sv
// Mario motion sequencer for the 640x480 playfield.
// Holds the registered sprite position and runs a GROUND/RISE/FALL FSM.
// Motion happens only on frame_tick. The ground flag comes combinationally from
// the bar collision check, which looks at the registered position.
//
// Handshake: this block has no valid/ready pair. frame_tick acts as the one-cycle
// "advance" strobe. All outputs are registers, so the result of a tick is visible
// on the cycle after frame_tick and then holds until the next tick.
module mario_jump_ctrl #(
    parameter int X_INIT      = 40,
    parameter int Y_INIT      = 400,
    parameter int X_STEP      = 2,
    parameter int X_MAX       = 623,
    parameter int Y_MAX       = 463,
    parameter int JUMP_V      = 6,
    parameter int GRAVITY_DIV = 2,
    parameter int MAX_FALL    = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_jump,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       ground,
    output logic [9:0] mario_x,
    output logic [9:0] mario_y,
    output logic [1:0] state,
    output logic       on_ground
);

    // The gravity divider counter is at least one bit wide, even when GRAVITY_DIV is 1.
    localparam int GW = (GRAVITY_DIV > 1) ? $clog2(GRAVITY_DIV) : 1;

    localparam logic [9:0]    X_INIT_Q   = 10'(X_INIT);
    localparam logic [9:0]    Y_INIT_Q   = 10'(Y_INIT);
    localparam logic [9:0]    X_STEP_Q   = 10'(X_STEP);
    localparam logic [10:0]   X_STEP_W   = 11'(X_STEP);
    localparam logic [10:0]   X_MAX_W    = 11'(X_MAX);
    localparam logic [9:0]    X_MAX_Q    = 10'(X_MAX);
    localparam logic [10:0]   Y_MAX_W    = 11'(Y_MAX);
    localparam logic [9:0]    Y_MAX_Q    = 10'(Y_MAX);
    localparam logic [3:0]    JUMP_V_Q   = 4'(JUMP_V);
    localparam logic [3:0]    MAX_FALL_Q = 4'(MAX_FALL);
    localparam logic [GW-1:0] GCNT_LAST  = GW'(GRAVITY_DIV - 1);

    typedef enum logic [1:0] {
        ST_GROUND = 2'b00,
        ST_RISE   = 2'b01,
        ST_FALL   = 2'b10,
        ST_BAD    = 2'b11
    } state_t;

    state_t        st_q, st_n;
    logic [9:0]    x_q, x_n;
    logic [9:0]    y_q, y_n;
    logic [3:0]    vel_q, vel_n;
    logic [GW-1:0] gcnt_q, gcnt_n;
    logic          jump_req_q;
    logic          btn_jump_d_q;

    logic          jump_edge;
    logic          jump_now;
    logic          gcnt_last;
    logic [10:0]   x_inc;
    logic [10:0]   y_sum;
    logic [9:0]    vel_ext;

    // A press is a rising edge of btn_jump. An edge that arrives on the tick cycle
    // itself still counts for that tick.
    assign jump_edge = btn_jump & ~btn_jump_d_q;
    assign jump_now  = jump_req_q | jump_edge;
    assign gcnt_last = (gcnt_q == GCNT_LAST);
    assign vel_ext   = {6'd0, vel_q};
    assign x_inc     = {1'b0, x_q} + X_STEP_W;
    assign y_sum     = {1'b0, y_q} + {7'd0, vel_q};

    // Update the state, position, velocity and jump-latch registers. Reset is async.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= ST_FALL;
            x_q          <= X_INIT_Q;
            y_q          <= Y_INIT_Q;
            vel_q        <= 4'd0;
            gcnt_q       <= '0;
            jump_req_q   <= 1'b0;
            btn_jump_d_q <= 1'b0;
        end else begin
            st_q         <= st_n;
            x_q          <= x_n;
            y_q          <= y_n;
            vel_q        <= vel_n;
            gcnt_q       <= gcnt_n;
            btn_jump_d_q <= btn_jump;
            // Every tick drops the request, whether it was used or not.
            // This stops a stale press from firing a jump later.
            if (frame_tick) begin
                jump_req_q <= 1'b0;
            end else if (jump_edge) begin
                jump_req_q <= 1'b1;
            end
        end
    end

    // Compute the next-tick motion. Everything holds between ticks.
    always_comb begin
        st_n   = st_q;
        x_n    = x_q;
        y_n    = y_q;
        vel_n  = vel_q;
        gcnt_n = gcnt_q;

        if (frame_tick) begin
            // Horizontal movement is independent of the vertical state.
            // Pressing both buttons cancels out.
            if (btn_left && !btn_right) begin
                if (x_q < X_STEP_Q) begin
                    x_n = 10'd0;
                end else begin
                    x_n = x_q - X_STEP_Q;
                end
            end else if (btn_right && !btn_left) begin
                if (x_inc > X_MAX_W) begin
                    x_n = X_MAX_Q;
                end else begin
                    x_n = x_inc[9:0];
                end
            end

            case (st_q)
                ST_GROUND: begin
                    // A jump takes priority over walking off a ledge on the same tick.
                    if (jump_now) begin
                        st_n   = ST_RISE;
                        vel_n  = JUMP_V_Q;
                        gcnt_n = '0;
                    end else if (!ground) begin
                        st_n   = ST_FALL;
                        vel_n  = 4'd0;
                        gcnt_n = '0;
                    end
                end

                ST_RISE: begin
                    // Apply the current velocity first, then let gravity act on it.
                    // Bars do not stop an upward move.
                    if (vel_ext >= y_q) begin
                        y_n    = 10'd0;
                        st_n   = ST_FALL;
                        vel_n  = 4'd0;
                        gcnt_n = '0;
                    end else begin
                        y_n = y_q - vel_ext;
                        if (gcnt_last) begin
                            gcnt_n = '0;
                            if (vel_q <= 4'd1) begin
                                vel_n = 4'd0;
                                st_n  = ST_FALL;
                            end else begin
                                vel_n = vel_q - 4'd1;
                            end
                        end else begin
                            gcnt_n = gcnt_q + GW'(1);
                        end
                    end
                end

                ST_FALL: begin
                    if (ground) begin
                        st_n   = ST_GROUND;
                        vel_n  = 4'd0;
                        gcnt_n = '0;
                    end else if (y_sum >= Y_MAX_W) begin
                        // The bottom edge of the screen behaves like a floor.
                        y_n    = Y_MAX_Q;
                        st_n   = ST_GROUND;
                        vel_n  = 4'd0;
                        gcnt_n = '0;
                    end else begin
                        y_n = y_sum[9:0];
                        if (gcnt_last) begin
                            gcnt_n = '0;
                            if (vel_q >= MAX_FALL_Q) begin
                                vel_n = MAX_FALL_Q;
                            end else begin
                                vel_n = vel_q + 4'd1;
                            end
                        end else begin
                            gcnt_n = gcnt_q + GW'(1);
                        end
                    end
                end

                default: begin
                    // The unused encoding recovers into a fall from rest.
                    st_n   = ST_FALL;
                    vel_n  = 4'd0;
                    gcnt_n = '0;
                end
            endcase
        end
    end

    assign mario_x   = x_q;
    assign mario_y   = y_q;
    assign state     = st_q;
    assign on_ground = (st_q == ST_GROUND);

endmodule

// File: tb/tb_mario_jump_ctrl.sv
// Bench for mario_jump_ctrl.
// The driver issues frame ticks and queues a hand-computed {state, on_ground, x, y}
// for each one. The monitor pops and compares on the cycle after each tick.
module tb_mario_jump_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       btn_jump;
    logic       btn_left;
    logic       btn_right;
    logic       ground;
    logic [9:0] mario_x;
    logic [9:0] mario_y;
    logic [1:0] state;
    logic       on_ground;

    int          total = 0;
    int          bad   = 0;
    logic [22:0] exp_q[$];
    string       name_q[$];
    logic        tick_d;

    mario_jump_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_jump   (btn_jump),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .ground     (ground),
        .mario_x    (mario_x),
        .mario_y    (mario_y),
        .state      (state),
        .on_ground  (on_ground)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] pack(input logic [1:0] st, input logic [9:0] x, input logic [9:0] y);
        return {st, (st == 2'b00), x, y};
    endfunction

    task automatic check(input string n, input logic [22:0] act, input logic [22:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got st=%0d og=%0d x=%0d y=%0d, want st=%0d og=%0d x=%0d y=%0d",
                     n, act[22:21], act[20], act[19:10], act[9:0],
                     exp[22:21], exp[20], exp[19:10], exp[9:0]);
        end
    endtask

    // The DUT shows a result on the cycle after each tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_d <= 1'b0;
        else        tick_d <= frame_tick;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [22:0] e;
        string       n;
        if (tick_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got x=%0d y=%0d st=%0d, want nothing queued",
                         mario_x, mario_y, state);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check(n, {state, on_ground, mario_x, mario_y}, e);
            end
        end
    end

    // driver tasks
    task automatic do_tick(input string n, input logic jump_at_tick,
                           input logic [1:0] es, input logic [9:0] ex, input logic [9:0] ey);
        @(negedge clk);
        frame_tick = 1'b1;
        if (jump_at_tick) btn_jump = 1'b1;
        exp_q.push_back(pack(es, ex, ey));
        name_q.push_back(n);
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic press_jump();
        @(negedge clk);
        btn_jump = 1'b1;
        @(negedge clk);
        btn_jump = 1'b0;
    endtask

    int rise_y[12] = '{394, 388, 383, 378, 374, 370, 367, 364, 362, 360, 359, 358};
    int fall_y[18] = '{400, 400, 401, 402, 404, 406, 409, 412, 416, 420, 425, 430,
                       436, 442, 448, 454, 460, 463};

    initial begin
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        btn_jump   = 1'b0;
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        ground     = 1'b1;
        #12;
        check("reset_values", {state, on_ground, mario_x, mario_y}, pack(2'b10, 10'd40, 10'd400));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: first tick lands on a bar.
        do_tick("first_tick_ground", 1'b0, 2'b00, 10'd40, 10'd400);

        // 2: full jump arc with gravity every second tick.
        press_jump();
        do_tick("jump_start", 1'b0, 2'b01, 10'd40, 10'd400);
        @(negedge clk);
        @(negedge clk);
        check("hold_between_ticks", {state, on_ground, mario_x, mario_y}, pack(2'b01, 10'd40, 10'd400));
        for (int i = 0; i < 12; i++) begin
            do_tick("rise_arc", 1'b0, (i == 11) ? 2'b10 : 2'b01, 10'd40, 10'(rise_y[i]));
        end
        ground = 1'b0;
        do_tick("fall_from_apex", 1'b0, 2'b10, 10'd40, 10'd358);
        do_tick("fall_from_apex", 1'b0, 2'b10, 10'd40, 10'd358);
        do_tick("fall_from_apex", 1'b0, 2'b10, 10'd40, 10'd359);
        ground = 1'b1;
        do_tick("land_on_bar", 1'b0, 2'b00, 10'd40, 10'd359);
        do_tick("stay_landed", 1'b0, 2'b00, 10'd40, 10'd359);

        // A press on the tick cycle itself counts for that tick.
        do_tick("jump_on_tick", 1'b1, 2'b01, 10'd40, 10'd359);
        do_tick("rise_after_tick_jump", 1'b0, 2'b01, 10'd40, 10'd353);
        do_tick("rise_after_tick_jump", 1'b0, 2'b01, 10'd40, 10'd347);

        // 6: reset mid-rise takes effect without a clock edge.
        #2;
        rst_n    = 1'b0;
        btn_jump = 1'b0;
        #1;
        check("async_reset_mid_rise", {state, on_ground, mario_x, mario_y}, pack(2'b10, 10'd40, 10'd400));
        #1;
        rst_n = 1'b1;
        do_tick("resume_after_reset", 1'b0, 2'b00, 10'd40, 10'd400);

        // 3 and 5: walk off, accelerate to terminal speed, land on the bottom clamp.
        // Holding jump across the landing must not trigger a new jump.
        ground = 1'b0;
        do_tick("walk_off", 1'b0, 2'b10, 10'd40, 10'd400);
        for (int i = 0; i < 18; i++) begin
            if (i == 15) begin
                @(negedge clk);
                btn_jump = 1'b1;
            end
            do_tick("fall_accel", 1'b0, (i == 17) ? 2'b00 : 2'b10, 10'd40, 10'(fall_y[i]));
        end
        ground = 1'b1;
        do_tick("held_jump_no_rejump", 1'b0, 2'b00, 10'd40, 10'd463);
        do_tick("held_jump_no_rejump", 1'b0, 2'b00, 10'd40, 10'd463);
        @(negedge clk);
        btn_jump = 1'b0;
        do_tick("released_still_ground", 1'b0, 2'b00, 10'd40, 10'd463);
        press_jump();
        do_tick("rejump_after_release", 1'b0, 2'b01, 10'd40, 10'd463);
        do_tick("rejump_rise", 1'b0, 2'b01, 10'd40, 10'd457);

        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_second", {state, on_ground, mario_x, mario_y}, pack(2'b10, 10'd40, 10'd400));
        #1;
        rst_n = 1'b1;
        do_tick("ground_after_reset", 1'b0, 2'b00, 10'd40, 10'd400);

        // 4: horizontal clamps at both edges, and both buttons cancel.
        btn_right = 1'b1;
        for (int k = 1; k <= 291; k++) begin
            do_tick("walk_right", 1'b0, 2'b00, 10'(40 + 2 * k), 10'd400);
        end
        do_tick("right_clamp", 1'b0, 2'b00, 10'd623, 10'd400);
        do_tick("right_clamp", 1'b0, 2'b00, 10'd623, 10'd400);
        btn_left = 1'b1;
        do_tick("both_buttons_hold", 1'b0, 2'b00, 10'd623, 10'd400);
        btn_right = 1'b0;
        for (int k = 1; k <= 311; k++) begin
            do_tick("walk_left", 1'b0, 2'b00, 10'(623 - 2 * k), 10'd400);
        end
        do_tick("left_clamp_from_1", 1'b0, 2'b00, 10'd0, 10'd400);
        do_tick("left_clamp_at_0", 1'b0, 2'b00, 10'd0, 10'd400);
        btn_right = 1'b1;
        do_tick("both_buttons_at_0", 1'b0, 2'b00, 10'd0, 10'd400);
        btn_left  = 1'b0;
        btn_right = 1'b0;
        do_tick("no_buttons", 1'b0, 2'b00, 10'd0, 10'd400);

        // final report
        @(negedge clk);
        @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
